icache_refill_mem: RTL and testbench

Memory-side responder for instruction-cache line refills. It accepts one line-refill read request over a valid/ready address channel and returns the full 64-byte line as eight 64-bit beats over a valid/ready data channel, with `rlast` on the final beat. The latency before the first beat is programmable. It holds a byte-addressable backing array that the simulation top can preload. It sits behind the icache's memory-read path and is the other end of the refill handshake the cache's `CACHE_MEMREAD` state waits on.

---
 rtl/icache_refill_pkg.sv | 21 ++
 rtl/refill_mem_array.sv | 34 +++
 rtl/icache_refill_mem.sv | 182 ++++++++++++++++++
 tb/tb_icache_refill_mem.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_refill_pkg.sv
// Shared types and constants for the icache line-refill memory responder.
//   state_e        : refill FSM states
//   RESP_*         : read response codes
//   BEATS_PER_LINE : beats per refill line, BEAT_IDX_W bits of beat index
//   addr_in_range  : true when an address lies inside the backing window
package icache_refill_pkg;

    typedef enum logic [1:0] {StIdle, StWait, StBurst} state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned BEATS_PER_LINE = 8;
    localparam int unsigned BEAT_IDX_W     = $clog2(BEATS_PER_LINE);

    function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] base,
                                           input int unsigned bytes);
        return (addr >= base) && ((addr - base) < bytes);
    endfunction

endpackage

// File: rtl/refill_mem_array.sv
// Backing store for the refill responder: WORDS x 64-bit words.
//   clk           : write clock
//   we/waddr      : synchronous write enable and word index
//   wdata/wstrb   : write data and per-byte enables
//   raddr/rdata   : combinational read port
// Contents are deliberately not reset so preloaded images survive a reset.
module refill_mem_array #(
    parameter int unsigned WORDS = 8192,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [63:0]   wdata,
    input  logic [7:0]    wstrb,
    input  logic [AW-1:0] raddr,
    output logic [63:0]   rdata
);

    logic [63:0] mem_q [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 8; b++) begin
                if (wstrb[b]) begin
                    mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/icache_refill_mem.sv
// Memory-side responder for instruction-cache line refills.
//   clk, rst                 : clock, asynchronous active-low reset
//   arvalid/arready/araddr   : refill request channel (line-aligned internally)
//   rvalid/rready/rdata      : eight 64-bit beats per line, lowest address first
//   rresp/rlast              : SLVERR for out-of-window lines, rlast on beat 7
//   wen/waddr/wdata/wstrb    : byte-masked preload port, usable in every state
// All outputs come straight from flops.
module icache_refill_mem
    import icache_refill_pkg::*;
#(
    parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
    parameter int unsigned MEM_BYTES  = 65536,
    parameter int unsigned LINE_BYTES = 64,
    parameter int unsigned BEAT_BYTES = 8,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [63:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    input  logic        wen,
    input  logic [31:0] waddr,
    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb
);

    localparam int unsigned WORDS     = MEM_BYTES / BEAT_BYTES;
    localparam int unsigned AW        = $clog2(WORDS);
    localparam int unsigned LW        = AW - BEAT_IDX_W;
    localparam logic [31:0] LINE_MASK = ~(32'(LINE_BYTES) - 32'd1);

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [BEAT_IDX_W-1:0]   beat_q, beat_d;
    logic [LW-1:0]           line_q, line_d;
    logic                    err_q, err_d;
    logic                    arready_q, arready_d;
    logic                    rvalid_q, rvalid_d;
    logic [63:0]             rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic                    rlast_q, rlast_d;

    logic [31:0]             req_line, req_ofs, wr_ofs;
    logic                    req_err, wr_ok;
    logic                    load;
    logic [BEAT_IDX_W-1:0]   load_idx;
    logic [63:0]             rd_word;
    logic                    unused_bits;

    assign req_line = araddr & LINE_MASK;
    assign req_ofs  = req_line - MEM_BASE;
    assign req_err  = !addr_in_range(req_line, MEM_BASE, MEM_BYTES);
    assign wr_ofs   = waddr - MEM_BASE;
    // Out-of-window preload writes are silently dropped.
    assign wr_ok    = wen && addr_in_range(waddr, MEM_BASE, MEM_BYTES);

    assign unused_bits = ^{req_ofs[31:AW+3], req_ofs[BEAT_IDX_W+2:0],
                           wr_ofs[31:AW+3], wr_ofs[2:0]};

    refill_mem_array #(
        .WORDS (WORDS)
    ) u_array (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ofs[AW+2:3]),
        .wdata (wdata),
        .wstrb (wstrb),
        .raddr ({line_q, load_idx}),
        .rdata (rd_word)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        beat_d    = beat_q;
        line_d    = line_q;
        err_d     = err_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        load      = 1'b0;
        load_idx  = beat_q;

        unique case (state_q)
            StIdle: begin
                arready_d = 1'b1;
                if (arvalid && arready_q) begin
                    line_d    = req_ofs[AW+2:BEAT_IDX_W+3];
                    err_d     = req_err;
                    beat_d    = '0;
                    arready_d = 1'b0;
                    if (LATENCY == 0) begin
                        state_d = StBurst;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(LATENCY);
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d  = StBurst;
                    load     = 1'b1;
                    load_idx = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StBurst: begin
                if (!rvalid_q) begin
                    // Zero-latency entry: first beat not yet presented.
                    load     = 1'b1;
                    load_idx = beat_q;
                end else if (rready) begin
                    if (beat_q == BEAT_IDX_W'(BEATS_PER_LINE - 1)) begin
                        state_d   = StIdle;
                        beat_d    = '0;
                        arready_d = 1'b1;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        rresp_d   = RESP_OKAY;
                        rdata_d   = '0;
                    end else begin
                        beat_d   = beat_q + 1'b1;
                        load     = 1'b1;
                        load_idx = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A beat's data is sampled from the array only when it is first presented.
        if (load) begin
            rvalid_d = 1'b1;
            rdata_d  = err_q ? '0 : rd_word;
            rresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
            rlast_d  = (load_idx == BEAT_IDX_W'(BEATS_PER_LINE - 1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            beat_q    <= '0;
            line_q    <= '0;
            err_q     <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            beat_q    <= beat_d;
            line_q    <= line_d;
            err_q     <= err_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;

endmodule

// File: tb/tb_icache_refill_mem.sv
// Self-checking bench for icache_refill_mem: a LATENCY=2 instance for most scenarios and a
// LATENCY=0 instance for back-to-back requests. Both share the preload port, so a single
// word-level memory model (associative array) predicts the lines either one returns.
module tb_icache_refill_mem;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int unsigned BYTES = 65536;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        arvalid = 1'b0, rready = 1'b0;
    logic [31:0] araddr = '0;
    logic        arready, rvalid, rlast;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        arvalid0 = 1'b0, rready0 = 1'b0;
    logic [31:0] araddr0 = '0;
    logic        arready0, rvalid0, rlast0;
    logic [63:0] rdata0;
    logic [1:0]  rresp0;
    logic        wen = 1'b0;
    logic [31:0] waddr = '0;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] model_mem [int unsigned];
    logic [63:0] exp_word [8];
    logic [1:0]  exp_resp;

    always #5 clk = ~clk;

    icache_refill_mem #(.LATENCY(2)) u_dut (
        .clk(clk), .rst(rst), .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .wen(wen), .waddr(waddr), .wdata(wdata), .wstrb(wstrb)
    );

    icache_refill_mem #(.LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst), .arvalid(arvalid0), .arready(arready0), .araddr(araddr0),
        .rvalid(rvalid0), .rready(rready0), .rdata(rdata0), .rresp(rresp0), .rlast(rlast0),
        .wen(wen), .waddr(waddr), .wdata(wdata), .wstrb(wstrb)
    );

    function automatic void model_write(logic [31:0] a, logic [63:0] d, logic [7:0] s);
        logic [31:0] o;
        logic [63:0] w;
        int unsigned key;
        if (a < BASE) return;
        o = a - BASE;
        if (o >= BYTES) return;
        key = int'(o >> 3);
        w = model_mem.exists(key) ? model_mem[key] : 64'h0;
        for (int b = 0; b < 8; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        model_mem[key] = w;
    endfunction

    // Expected beats for a request, straight from the addressing rules.
    function automatic void expect_line(logic [31:0] a);
        logic [31:0] line;
        line = a & ~32'h3F;
        if (line < BASE || (line - BASE) >= BYTES) begin
            exp_resp = 2'b10;
            for (int k = 0; k < 8; k++) exp_word[k] = 64'h0;
        end else begin
            exp_resp = 2'b00;
            for (int k = 0; k < 8; k++) exp_word[k] = model_mem[int'((line - BASE) >> 3) + k];
        end
    endfunction

    task automatic write_word(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        @(negedge clk);
        wen = 1'b1; waddr = a; wdata = d; wstrb = s;
        model_write(a, d, s);
        @(negedge clk);
        wen = 1'b0;
    endtask

    // One request on the LATENCY=2 instance, checked beat by beat against exp_word/exp_resp.
    // mode: 0 rready high, 1 rready 1,0,0 repeating, 2 random. Optional preload write when
    // beat wr_k is on the bus, optional reset when beat rst_k is on the bus.
    task automatic burst(input logic [31:0] addr, input int mode, input int wr_k,
                         input logic [31:0] wr_a, input logic [63:0] wr_d, input logic [7:0] wr_s,
                         input int rst_k, input string name, output int lat);
        int c, hs, p, guard;
        logic rr, wrote;
        lat = -1; hs = 0; p = 0; guard = 0; wrote = 1'b0;
        @(negedge clk);
        arvalid = 1'b1; araddr = addr;
        while (arready !== 1'b1) begin
            @(negedge clk);
            guard++;
            if (guard > 40) begin
                vectors++; miscompares++;
                $display("FAIL %s arready timeout: got %b want 1", name, arready);
                arvalid = 1'b0;
                return;
            end
        end
        @(negedge clk);
        c = 1;
        arvalid = 1'b0; araddr = $urandom;
        vectors++;
        if (arready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s arready while busy: got %b want 0", name, arready);
        end
        while (hs < 8) begin
            if (c > 200) begin
                vectors++; miscompares++;
                $display("FAIL %s beat timeout: got %0d beats want 8", name, hs);
                break;
            end
            if (rvalid === 1'b1) begin
                if (lat < 0) lat = c - 1;
                vectors++;
                if (rdata !== exp_word[hs] || rresp !== exp_resp || rlast !== (hs == 7)) begin
                    miscompares++;
                    $display("FAIL %s beat %0d: got data %h resp %b last %b want %h %b %b",
                             name, hs, rdata, rresp, rlast, exp_word[hs], exp_resp, hs == 7);
                end
                if (rst_k == hs) begin
                    rst = 1'b0;
                    rready = 1'b0;
                    #1;
                    vectors++;
                    if (rvalid !== 1'b0) begin
                        miscompares++;
                        $display("FAIL %s rvalid on reset: got %b want 0", name, rvalid);
                    end
                    repeat (2) @(negedge clk);
                    vectors++;
                    if (arready !== 1'b0 || rvalid !== 1'b0) begin
                        miscompares++;
                        $display("FAIL %s in reset: got arready %b rvalid %b want 0 0",
                                 name, arready, rvalid);
                    end
                    rst = 1'b1;
                    @(negedge clk);
                    vectors++;
                    if (arready !== 1'b1 || rvalid !== 1'b0) begin
                        miscompares++;
                        $display("FAIL %s after release: got arready %b rvalid %b want 1 0",
                                 name, arready, rvalid);
                    end
                    return;
                end
                if (wr_k == hs && !wrote) begin
                    wen = 1'b1; waddr = wr_a; wdata = wr_d; wstrb = wr_s;
                    model_write(wr_a, wr_d, wr_s);
                    wrote = 1'b1;
                end else begin
                    wen = 1'b0;
                end
                rr = (mode == 0) ? 1'b1 : (mode == 1) ? (p % 3 == 0) : 1'($urandom);
                p++;
                rready = rr;
                if (rr) hs++;
            end else begin
                wen = 1'b0;
                rready = 1'($urandom);
            end
            @(negedge clk);
            c++;
        end
        rready = 1'b0; wen = 1'b0;
        vectors++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s after rlast: got rvalid %b arready %b want 0 1",
                     name, rvalid, arready);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        vectors++;
        if (arready !== 1'b0 || rvalid !== 1'b0 || rlast !== 1'b0 || rresp !== 2'b00 ||
            rdata !== 64'h0 || arready0 !== 1'b0 || rvalid0 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset values: got arready %b rvalid %b rlast %b rresp %b rdata %h",
                     arready, rvalid, rlast, rresp, rdata);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (arready !== 1'b1 || arready0 !== 1'b1) begin
            miscompares++;
            $display("FAIL arready after release: got %b %b want 1 1", arready, arready0);
        end
    endtask

    task automatic preload;
        for (int w = 0; w < 128; w++) write_word(BASE + 32'(8 * w), {$urandom, $urandom}, 8'hFF);
        for (int k = 0; k < 8; k++)
            write_word(BASE + 32'h40 + 32'(8 * k), 64'h1111_0000_0000_0000 + 64'(k), 8'hFF);
        write_word(BASE, 64'h0123_4567_89AB_CDEF, 8'hFF);
    endtask

    task automatic test_basic;
        int lat;
        expect_line(32'h8000_0047);
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (exp_word[k] !== 64'h1111_0000_0000_0000 + 64'(k)) begin
                miscompares++;
                $display("FAIL model word %0d: got %h", k, exp_word[k]);
            end
        end
        burst(32'h8000_0047, 0, -1, '0, '0, '0, -1, "basic", lat);
        vectors++;
        if (lat != 3) begin
            miscompares++;
            $display("FAIL basic latency: got %0d want 3", lat);
        end
    endtask

    task automatic test_backpressure;
        int lat;
        expect_line(32'h8000_0047);
        burst(32'h8000_0047, 1, -1, '0, '0, '0, -1, "backpressure", lat);
        vectors++;
        if (lat != 3) begin
            miscompares++;
            $display("FAIL backpressure latency: got %0d want 3", lat);
        end
    endtask

    task automatic test_error;
        int lat;
        expect_line(32'h7FFF_FFC0);
        burst(32'h7FFF_FFC0, 0, -1, '0, '0, '0, -1, "err_low", lat);
        expect_line(32'h8001_0000);
        burst(32'h8001_0000, 2, -1, '0, '0, '0, -1, "err_high", lat);
        vectors++;
        if (lat != 3) begin
            miscompares++;
            $display("FAIL err latency: got %0d want 3", lat);
        end
    endtask

    task automatic test_write_during_burst;
        int lat;
        expect_line(BASE);
        exp_word[7][7:0] = 8'hAA;
        burst(BASE, 0, 3, BASE + 32'h38, 64'hAA, 8'h01, -1, "write_future_beat", lat);
        expect_line(BASE);
        burst(BASE, 0, 3, BASE, 64'hAA, 8'h01, -1, "write_taken_beat", lat);
        expect_line(BASE);
        vectors++;
        if (exp_word[0] !== 64'h0123_4567_89AB_CDAA) begin
            miscompares++;
            $display("FAIL model word 0: got %h want 0123456789abcdaa", exp_word[0]);
        end
        burst(BASE, 0, -1, '0, '0, '0, -1, "write_landed", lat);
    endtask

    task automatic test_reset_mid_burst;
        int lat;
        expect_line(BASE + 32'h80);
        burst(BASE + 32'h80, 0, -1, '0, '0, '0, 4, "reset_mid_burst", lat);
        expect_line(BASE + 32'h80);
        burst(BASE + 32'h80, 0, -1, '0, '0, '0, -1, "after_reset", lat);
    endtask

    task automatic test_random;
        int lat;
        logic [31:0] a;
        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < 3; j++)
                write_word(BASE + 32'(($urandom % 128) * 8), {$urandom, $urandom}, 8'($urandom));
            // Dropped: aliasing onto the low lines would corrupt what the model predicts.
            write_word(32'h8001_0000 + 32'(($urandom % 16) * 8), {$urandom, $urandom}, 8'hFF);
            if ($urandom % 5 == 0) begin
                case ($urandom % 4)
                    0: a = 32'h7FFF_FFC0;
                    1: a = 32'h8001_0000;
                    2: a = 32'h0000_0040;
                    default: a = 32'hFFFF_FFC0;
                endcase
            end else begin
                a = BASE + 32'(($urandom % 16) * 64) + 32'($urandom % 64);
            end
            expect_line(a);
            burst(a, 2, -1, '0, '0, '0, -1, "random", lat);
            vectors++;
            if (lat != 3) begin
                miscompares++;
                $display("FAIL random latency: got %0d want 3 addr %h", lat, a);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] e [16];
        int c, n, first_c, last_c, hs2_c, first2_c, guard;
        expect_line(BASE + 32'h100);
        for (int k = 0; k < 8; k++) e[k] = exp_word[k];
        expect_line(BASE + 32'h40);
        for (int k = 0; k < 8; k++) e[8 + k] = exp_word[k];
        n = 0; first_c = -1; last_c = -1; hs2_c = -1; first2_c = -1; guard = 0;
        @(negedge clk);
        arvalid0 = 1'b1; araddr0 = BASE + 32'h100; rready0 = 1'b1;
        while (arready0 !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        c = 0;
        while (n < 16 && c < 60) begin
            @(negedge clk);
            c++;
            if (c == 1) araddr0 = BASE + 32'h40;
            if (hs2_c >= 0 && c > hs2_c) arvalid0 = 1'b0;
            if (rvalid0 === 1'b1) begin
                vectors++;
                if (rdata0 !== e[n] || rresp0 !== 2'b00 || rlast0 !== (n % 8 == 7)) begin
                    miscompares++;
                    $display("FAIL b2b beat %0d: got %h %b %b want %h 00 %b",
                             n, rdata0, rresp0, rlast0, e[n], n % 8 == 7);
                end
                if (n == 0) first_c = c;
                if (n == 7) last_c = c;
                if (n == 8) first2_c = c;
                n++;
            end
            if (arready0 === 1'b1 && n >= 8 && hs2_c < 0) hs2_c = c;
        end
        arvalid0 = 1'b0; rready0 = 1'b0;
        vectors++;
        if (n != 16 || first_c != 2) begin
            miscompares++;
            $display("FAIL b2b first burst: got %0d beats first at %0d want 16 at 2", n, first_c);
        end
        vectors++;
        if (hs2_c != last_c + 1 || first2_c != hs2_c + 2) begin
            miscompares++;
            $display("FAIL b2b spacing: got accept %0d first %0d want %0d %0d",
                     hs2_c, first2_c, last_c + 1, last_c + 3);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        preload();
        test_basic();
        test_backpressure();
        test_error();
        test_write_during_burst();
        test_reset_mid_burst();
        test_random();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
